// File: rtl/fir_param.sv
// fir_param: parametrised, pipelined direct-form FIR filter.
// Three register stages: delay line, per-tap products, rounded/saturated output.
// Coefficients are written into a shadow bank and copied atomically to the
// active bank on commit, so every output is computed with exactly one set.
module fir_param #(
   parameter int TAPS   = 4,
   parameter int DATA_W = 17,
   parameter int COEF_W = 17,
   parameter int OUT_W  = 36,
   parameter int SHIFT  = 0,
   localparam int AW    = $clog2(TAPS),
   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic                     in_data_vld,
   input  logic                     flush,
   input  logic                     coef_wr,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     coef_commit,
   output logic signed [OUT_W-1:0]  y_out,
   output logic                     out_data_vld,
   output logic                     out_sat
);

   localparam int PROD_W = DATA_W + COEF_W;
   // Rounded value is carried one bit wider than the accumulator so the
   // rounding bias can never overflow.
   localparam int RW = ACC_W + 1;
   // Saturation compare width covers both the rounded value and the output.
   localparam int CW = (RW > OUT_W) ? RW : OUT_W;

   localparam logic signed [RW-1:0] RND_BIAS =
      (SHIFT > 0) ? (RW'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : RW'(0);
   localparam logic signed [CW-1:0] Y_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CW-1:0] Y_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [DATA_W-1:0] dly_p1 [TAPS];
   logic                     vld_p1;
   logic signed [COEF_W-1:0] coef_shadow [TAPS];
   logic signed [COEF_W-1:0] coef_active [TAPS];
   logic signed [PROD_W-1:0] prod_p2 [TAPS];
   logic                     vld_p2;
   logic signed [ACC_W-1:0]  acc_p2;
   logic signed [RW-1:0]     rnd_p2;
   logic [OUT_W:0]           sat_p2;

   // Round half toward +inf: add half an LSB of the shifted result, then shift.
   function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] acc);
      logic signed [RW-1:0] ext;
      ext = RW'(acc);
      return (ext + RND_BIAS) >>> SHIFT;
   endfunction

   // Clip to the signed output range; MSB of the result is the clip flag.
   function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] r);
      logic signed [CW-1:0] rw;
      rw = CW'(r);
      if (rw > Y_MAX)
         return {1'b1, Y_MAX[OUT_W-1:0]};
      else if (rw < Y_MIN)
         return {1'b1, Y_MIN[OUT_W-1:0]};
      else
         return {1'b0, rw[OUT_W-1:0]};
   endfunction

   // Stage 1: sample delay line; flush clears it before a same-cycle shift-in
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) dly_p1[k] <= '0;
         vld_p1 <= 1'b0;
      end else begin
         if (in_data_vld) begin
            dly_p1[0] <= x_in;
            for (int k = 1; k < TAPS; k++)
               dly_p1[k] <= flush ? '0 : dly_p1[k-1];
         end else if (flush) begin
            for (int k = 0; k < TAPS; k++) dly_p1[k] <= '0;
         end
         vld_p1 <= in_data_vld;
      end
   end

   // Coefficient banks: writes land in shadow; commit copies shadow (including a same-cycle write) to active
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) begin
            coef_shadow[k] <= '0;
            coef_active[k] <= '0;
         end
      end else begin
         for (int k = 0; k < TAPS; k++) begin
            if (coef_wr && coef_addr == AW'(k))
               coef_shadow[k] <= coef_data;
            if (coef_commit)
               coef_active[k] <= (coef_wr && coef_addr == AW'(k)) ? coef_data : coef_shadow[k];
         end
      end
   end

   // Stage 2: per-tap products against the active coefficient set
   always_ff @(posedge clk) begin
      for (int k = 0; k < TAPS; k++)
         prod_p2[k] <= PROD_W'(dly_p1[k]) * PROD_W'(coef_active[k]);
   end

   // Stage 2 valid flag
   always_ff @(posedge clk) begin
      if (reset) vld_p2 <= 1'b0;
      else       vld_p2 <= vld_p1;
   end

   // Stage 3 combinational: adder tree with guard bits, then round and saturate
   always_comb begin
      acc_p2 = '0;
      for (int k = 0; k < TAPS; k++)
         acc_p2 = acc_p2 + ACC_W'(prod_p2[k]);
      rnd_p2 = round_shift(acc_p2);
      sat_p2 = saturate(rnd_p2);
   end

   // Stage 3: output register, updated only on valid so the value holds between pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         y_out        <= '0;
         out_sat      <= 1'b0;
         out_data_vld <= 1'b0;
      end else begin
         out_data_vld <= vld_p2;
         if (vld_p2)
            {out_sat, y_out} <= sat_p2;
      end
   end

endmodule

// File: tb/tb_fir_param.sv
// Testbench for fir_param: three instances (default, 32-bit saturating,
// 3-tap with SHIFT=1) share stimulus buses; sel gates which one is driven.
module tb_fir_param;

   typedef struct {
      longint y;
      bit     sat;
      int     cyc;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               flush;
   logic               drv_vld, drv_wr, drv_commit;
   logic [1:0]         sel;
   logic signed [16:0] x;
   logic [1:0]         caddr;
   logic signed [16:0] cdata;

   logic vld0, vld1, vld2, wr0, wr1, wr2, cm0, cm1, cm2;
   logic signed [35:0] y0;
   logic signed [31:0] y1, y2;
   logic dv0, dv1, dv2, s0, s1, s2;

   exp_t q0[$], q1[$], q2[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit chk_hold = 1'b0;
   bit armed = 1'b0;
   int last_cyc = 0;
   logic signed [35:0] last_y = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign vld0 = drv_vld && (sel == 2'd0);
   assign vld1 = drv_vld && (sel == 2'd1);
   assign vld2 = drv_vld && (sel == 2'd2);
   assign wr0  = drv_wr && (sel == 2'd0);
   assign wr1  = drv_wr && (sel == 2'd1);
   assign wr2  = drv_wr && (sel == 2'd2);
   assign cm0  = drv_commit && (sel == 2'd0);
   assign cm1  = drv_commit && (sel == 2'd1);
   assign cm2  = drv_commit && (sel == 2'd2);

   fir_param dut0 (
      .clk(clk), .reset(reset), .x_in(x), .in_data_vld(vld0), .flush(flush),
      .coef_wr(wr0), .coef_addr(caddr), .coef_data(cdata), .coef_commit(cm0),
      .y_out(y0), .out_data_vld(dv0), .out_sat(s0));

   fir_param #(.OUT_W(32), .SHIFT(0)) dut1 (
      .clk(clk), .reset(reset), .x_in(x), .in_data_vld(vld1), .flush(flush),
      .coef_wr(wr1), .coef_addr(caddr), .coef_data(cdata), .coef_commit(cm1),
      .y_out(y1), .out_data_vld(dv1), .out_sat(s1));

   fir_param #(.TAPS(3), .OUT_W(32), .SHIFT(1)) dut2 (
      .clk(clk), .reset(reset), .x_in(x), .in_data_vld(vld2), .flush(flush),
      .coef_wr(wr2), .coef_addr(caddr), .coef_data(cdata), .coef_commit(cm2),
      .y_out(y2), .out_data_vld(dv2), .out_sat(s2));

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard pop for one instance whenever it presents an output
   task automatic mon(input int id, input logic vld, input logic signed [63:0] y, input logic sat);
      exp_t e;
      bit have;
      if (vld !== 1'b1) return;
      have = 1'b0;
      case (id)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_out dut%0d: actual y=%0d with no pending expected output", id, y);
      end else begin
         check($sformatf("y_dut%0d", id), y, 64'(e.y));
         check($sformatf("sat_dut%0d", id), 64'(sat), 64'(e.sat));
         check($sformatf("latency_dut%0d", id), 64'(cyc), 64'(e.cyc));
      end
   endtask

   // Monitor: compare outputs against the scoreboard; during gap test also check hold and spacing
   always @(negedge clk) begin
      mon(0, dv0, 64'(y0), s0);
      mon(1, dv1, 64'(y1), s1);
      mon(2, dv2, 64'(y2), s2);
      if (!chk_hold) armed = 1'b0;
      else if (dv0 === 1'b1) begin
         if (armed) check("pulse_gap", 64'(cyc - last_cyc), 64'd2);
         armed = 1'b1;
         last_cyc = cyc;
         last_y = y0;
      end else if (armed) begin
         check("hold_y", 64'(y0), 64'(last_y));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      drv_vld = 1'b0;
      drv_wr = 1'b0;
      drv_commit = 1'b0;
      flush = 1'b0;
   endtask

   task automatic wr_coef(input int a, input int v);
      caddr = 2'(a);
      cdata = 17'(v);
      drv_wr = 1'b1;
      tick();
   endtask

   task automatic commit();
      drv_commit = 1'b1;
      tick();
   endtask

   task automatic feed(input int xv);
      x = 17'(xv);
      drv_vld = 1'b1;
      tick();
   endtask

   task automatic send(input int xv, input longint ey, input bit es);
      exp_t e;
      feed(xv);
      e.y = ey;
      e.sat = es;
      e.cyc = cyc + 2;
      case (sel)
         2'd0: q0.push_back(e);
         2'd1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      check("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
   endtask

   int     xs [11] = '{3, 2, 1, 0, 1, 2, 3, 0, 0, 0, 0};
   longint ys [11] = '{0, 3, 8, 14, 8, 4, 4, 10, 12, 9, 0};

   initial begin
      reset = 1'b1; flush = 1'b0; drv_vld = 1'b0; drv_wr = 1'b0; drv_commit = 1'b0;
      sel = 2'd0; x = '0; caddr = '0; cdata = '0;
      tick();
      tick();
      @(negedge clk);
      check("rst_y0", 64'(y0), 64'd0);
      check("rst_vld0", 64'(dv0), 64'd0);
      check("rst_sat0", 64'(s0), 64'd0);
      check("rst_y1", 64'(y1), 64'd0);
      check("rst_vld1", 64'(dv1), 64'd0);
      check("rst_sat1", 64'(s1), 64'd0);
      check("rst_y2", 64'(y2), 64'd0);
      check("rst_vld2", 64'(dv2), 64'd0);
      check("rst_sat2", 64'(s2), 64'd0);
      reset = 1'b0;

      // Basic response, back-to-back
      for (int k = 0; k < 4; k++) wr_coef(k, k);
      commit();
      for (int i = 0; i < 11; i++) send(xs[i], ys[i], 1'b0);
      drain();

      // Valid gaps: sample every other cycle
      do_reset();
      for (int k = 0; k < 4; k++) wr_coef(k, k);
      commit();
      chk_hold = 1'b1;
      for (int i = 0; i < 11; i++) begin
         send(xs[i], ys[i], 1'b0);
         tick();
      end
      drain();
      chk_hold = 1'b0;

      // Coefficient commit mid-stream
      do_reset();
      for (int k = 0; k < 4; k++) wr_coef(k, 1);
      commit();
      send(1, 1, 1'b0); send(1, 2, 1'b0); send(1, 3, 1'b0); send(1, 4, 1'b0); send(1, 4, 1'b0);
      for (int k = 0; k < 4; k++) wr_coef(k, 2);
      send(1, 4, 1'b0); send(1, 4, 1'b0);
      commit();
      send(1, 8, 1'b0); send(1, 8, 1'b0);
      for (int k = 0; k < 4; k++) wr_coef(k, 3);
      send(1, 8, 1'b0);
      drv_commit = 1'b1;
      send(1, 12, 1'b0);
      send(1, 12, 1'b0);
      drain();

      // Saturation, OUT_W=32
      sel = 2'd1;
      do_reset();
      for (int k = 0; k < 4; k++) wr_coef(k, 65535);
      commit();
      for (int i = 0; i < 4; i++) send(65535, 64'sd2147483647, 1'b1);
      send(-65536, 64'sd2147483647, 1'b1);
      send(-65536, -64'sd131070, 1'b0);
      send(-65536, -64'sd2147483648, 1'b1);
      send(-65536, -64'sd2147483648, 1'b1);
      drain();

      // Rounding, SHIFT=1, 3 taps; slot 3 does not exist and must be ignored
      sel = 2'd2;
      do_reset();
      wr_coef(0, 3);
      wr_coef(3, 7);
      commit();
      send(1, 2, 1'b0);
      send(-1, -1, 1'b0);
      send(0, 0, 1'b0);
      send(1, 2, 1'b0);
      drain();

      // Flush with and without a same-cycle sample
      sel = 2'd0;
      do_reset();
      for (int k = 0; k < 4; k++) wr_coef(k, 1);
      commit();
      send(7, 7, 1'b0);
      send(7, 14, 1'b0);
      flush = 1'b1;
      send(5, 5, 1'b0);
      send(1, 6, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      send(2, 2, 1'b0);
      drain();

      // Reset with two samples in flight, dominating every other control
      feed(3);
      feed(4);
      reset = 1'b1;
      drv_vld = 1'b1; x = 17'sd9; flush = 1'b1;
      drv_wr = 1'b1; caddr = 2'd0; cdata = 17'sd9; drv_commit = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_y", 64'(y0), 64'd0);
      check("rst_mid_vld", 64'(dv0), 64'd0);
      check("rst_mid_sat", 64'(s0), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check("rst_no_pulse", 64'(dv0), 64'd0);
      end
      send(5, 0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fir_param.md
# fir_param

Parametrised, pipelined direct-form FIR filter; the next generation of the fixed 4-tap `fir` block. Taps, data, coefficient and output widths are parameters. Coefficients are loaded at run time through a double-buffered write port with atomic commit. The full-precision sum is rounded and saturated to the output width. It sits in the sample datapath between the input sample source and downstream processing, with a valid strobe on both sides.

## Interface
- `TAPS`, 4: number of taps, ≥2.
- `DATA_W`, 17: signed sample width.
- `COEF_W`, 17: signed coefficient width.
- `OUT_W`, 36: signed output width.
- `SHIFT`, 0: arithmetic right shift applied before saturation, 0..ACC_W-1.
- Derived: `ACC_W = DATA_W + COEF_W + clog2(TAPS)`; `AW = clog2(TAPS)`.

Ports:
- `clk`  in  1  sole clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `x_in`  in  DATA_W  signed input sample.
- `in_data_vld`  in  1  `x_in` is valid this cycle.
- `flush`  in  1  clears the delay line; coefficients are kept.
- `coef_wr`  in  1  write `coef_data` to shadow slot `coef_addr`.
- `coef_addr`  in  AW  shadow slot index, 0..TAPS-1.
- `coef_data`  in  COEF_W  signed coefficient value.
- `coef_commit`  in  1  copy the shadow bank to the active bank.
- `y_out`  out  OUT_W  signed filtered sample.
- `out_data_vld`  out  1  `y_out` is new this cycle (one-cycle pulse per accepted sample).
- `out_sat`  out  1  `y_out` was clipped; qualified by `out_data_vld`.

## Operation
- Filter equation, all arithmetic signed: y[n] = Σ_{k=0}^{TAPS-1} c[k]·x[n-k].
- Delay line: TAPS registers holding x[n]..x[n-TAPS+1].
  - It shifts only on edges where `in_data_vld`=1.
  - When `in_data_vld`=0 it holds; gaps do not insert zeros.
- Pipeline stage 1: the delay line plus valid flag v1.
- Pipeline stage 2: TAPS registered products, each DATA_W+COEF_W bits, computed with the *active* coefficients; valid flag v2.
- Pipeline stage 3: adder tree at ACC_W bits with no overflow possible. Then apply the shift and rounding, saturate, and register into `y_out`/`out_sat`; `out_data_vld` = v2 delayed one edge.
- Rounding (SHIFT>0): r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits. This is round half toward +∞. With SHIFT=0, r = acc.
- Saturation:
  - r > 2^(OUT_W-1)-1 → `y_out` = max, `out_sat`=1.
  - r < -2^(OUT_W-1) → `y_out` = min, `out_sat`=1.
  - Otherwise `y_out` is the sign-extended/truncated r and `out_sat`=0.
- `y_out` and `out_sat` hold their value between valid pulses.
- Coefficient banks: shadow and active, TAPS entries each.
  - `coef_wr` updates the shadow slot only.
  - `coef_wr` with `coef_addr` ≥ TAPS is ignored.
  - `coef_commit` copies the whole shadow bank to active in one edge. A `coef_wr` in the same cycle is included in the copy.
  - Every output uses exactly one coefficient set. Products registered on an edge after the commit edge use the new set; earlier products use the old set.
- `flush`:
  - Zeroes the delay line and v1.
  - If `in_data_vld`=1 in the same cycle, the delay line becomes {x_in, 0, …} and v1=1 (flush first, then shift).
  - Stages 2 and 3 drain normally.

## Timing
- Latency: a sample accepted at edge E produces `y_out`/`out_data_vld`=1 after edge E+2. Three register stages.
- Throughput: one sample per clock. Back-to-back valid inputs give back-to-back valid outputs.
- Reset, asserted on any edge including mid-stream, clears:
  - delay line, both coefficient banks, v1, v2: 0.
  - `y_out`=0, `out_data_vld`=0, `out_sat`=0.
- All in-flight samples are discarded on reset; there is no output pulse for them.
- Reset dominates `flush`, `coef_wr`, `coef_commit` and `in_data_vld` in the same cycle.
- First sample accepted the edge after `reset` deasserts → first `out_data_vld` two edges later.

## Test plan
- Basic response, defaults:
  - Stimulus: write shadow 0,1,2,3; commit; feed x = 3,2,1,0,1,2,3 then four zeros, back-to-back.
  - Required: `y_out` = 0,3,8,14,8,4,4,10,12,9,0, each with `out_data_vld`, first pulse after edge E+2, `out_sat`=0 throughout.
- Valid gaps:
  - Stimulus: same sequence with `in_data_vld` low every other cycle.
  - Required: identical output values; pulses spaced 2 cycles apart; `y_out` held between pulses.
- Coefficient commit mid-stream:
  - Stimulus: steady x=1 with coefficients 1,1,1,1 (y=4); write 2,2,2,2 to shadow without committing.
  - Required: y stays 4.
  - Stimulus: commit on an edge between two samples.
  - Required: outputs step 4→8 with no mixed value. An out-of-range write is ignored.
- Saturation and rounding, OUT_W=32, SHIFT=0:
  - Stimulus: all coefficients 65535 and x=65535 for 4 samples.
  - Required: y=2147483647, `out_sat`=1.
  - Stimulus: x=-65536 for 4 samples.
  - Required: y=-2147483648, `out_sat`=1.
  - Stimulus: SHIFT=1, acc=3 and acc=-3.
  - Required: y=2 and y=-1.
- Flush, reset, simultaneity:
  - `flush` together with a valid sample of 5, coefficients 1,1,1,1 → y=5.
  - `reset` asserted while 2 samples are in flight → no `out_data_vld`; all outputs 0 after the edge.
  - Coefficients read back as 0, so the next sample gives y=0.
